// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix calculator control path.
package matrix_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    WAIT_OP = 3'd1,
    LOAD_B  = 3'd2,
    RUN     = 3'd3,
    SHOW    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;

  localparam int unsigned DEF_W       = 8;
  localparam int unsigned DEF_ELEMS   = 4;
  localparam int unsigned DEF_TIMEOUT = 15;

  // Opcodes the ALU can execute; anything else is a keypad error.
  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/matrix_op_sequencer_elem_counter.sv
// Element index shared by the A and B load phases; wraps after ELEMS-1.
module elem_counter
  import matrix_pkg::*;
#(
  parameter int unsigned ELEMS = DEF_ELEMS,
  localparam int unsigned AW = $clog2(ELEMS)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clear,
  input  logic          inc,
  output logic [AW-1:0] idx,
  output logic          last
);

  logic [AW-1:0] idx_d;

  // Next index: clear wins over increment, increment wraps on the last element.
  always_comb begin
    idx_d = idx;
    if (clear) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = last ? '0 : AW'(idx + AW'(1));
    end
  end

  // last is kept as a register alongside idx so it is glitch-free.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx  <= '0;
      last <= 1'(ELEMS == 1);
    end else begin
      idx  <= idx_d;
      last <= (idx_d == AW'(ELEMS - 1));
    end
  end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Control FSM for the matrix calculator: loads A and B, launches the ALU,
// supervises completion with a timeout and holds the result for display.
module matrix_op_sequencer
  import matrix_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned ELEMS   = DEF_ELEMS,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  localparam int unsigned AW = $clog2(ELEMS)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [2:0]    op_code,
  input  logic          is_op,
  input  logic          is_enter,
  input  logic          num_valid,
  input  logic [W-1:0]  num_val,
  input  logic          alu_done,
  output logic          wr_en,
  output logic          wr_sel,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          alu_start,
  output logic [2:0]    alu_op,
  output logic          result_valid,
  output logic          busy,
  output logic          err,
  output logic [2:0]    state
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en_d, wr_sel_d, alu_start_d, result_valid_d, busy_d, err_d;
  logic [AW-1:0] wr_addr_d;
  logic [W-1:0]  wr_data_d;
  logic [2:0]    alu_op_d;
  logic          idx_clear_c, idx_inc_c, idx_last;
  logic [AW-1:0] idx;

  elem_counter #(.ELEMS(ELEMS)) u_elem_counter (
    .clk   (clk),
    .nrst  (nrst),
    .clear (idx_clear_c),
    .inc   (idx_inc_c),
    .idx   (idx),
    .last  (idx_last)
  );

  assign state = state_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    alu_start_d = 1'b0;
    alu_op_d    = alu_op;
    err_d       = 1'b0;
    idx_clear_c = 1'b0;
    idx_inc_c   = 1'b0;

    case (state_q)
      LOAD_A, LOAD_B: begin
        if (is_enter) begin
          state_d     = LOAD_A;
          idx_clear_c = 1'b1;
          alu_op_d    = 3'b000;
        end else begin
          if (is_op) err_d = 1'b1;
          if (num_valid) begin
            wr_en_d   = 1'b1;
            wr_sel_d  = (state_q == LOAD_B);
            wr_addr_d = idx;
            wr_data_d = num_val;
            idx_inc_c = 1'b1;
            if (idx_last) begin
              if (state_q == LOAD_A) begin
                state_d = WAIT_OP;
              end else begin
                // Start coincides with the final B write.
                state_d     = RUN;
                cnt_d       = '0;
                alu_start_d = 1'b1;
              end
            end
          end
        end
      end
      WAIT_OP: begin
        if (is_enter) begin
          state_d     = LOAD_A;
          idx_clear_c = 1'b1;
          alu_op_d    = 3'b000;
        end else if (is_op) begin
          if (op_supported(op_code)) begin
            alu_op_d = op_code;
            state_d  = LOAD_B;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // cnt_q == 0 marks the start cycle, where alu_done is not trusted.
        if ((cnt_q != '0) && alu_done) begin
          state_d = SHOW;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = FAULT;
          err_d   = 1'b1;
        end else begin
          cnt_d = CW'(cnt_q + CW'(1));
        end
      end
      SHOW: begin
        if (is_enter || is_op) begin
          state_d     = LOAD_A;
          idx_clear_c = 1'b1;
          alu_op_d    = 3'b000;
        end
      end
      FAULT: begin
        if (is_enter) begin
          state_d     = LOAD_A;
          idx_clear_c = 1'b1;
          alu_op_d    = 3'b000;
        end
      end
      default: begin
        state_d     = LOAD_A;
        idx_clear_c = 1'b1;
        alu_op_d    = 3'b000;
      end
    endcase

    result_valid_d = (state_d == SHOW);
    busy_d         = (state_d == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= LOAD_A;
      cnt_q        <= '0;
      wr_en        <= 1'b0;
      wr_sel       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      alu_start    <= 1'b0;
      alu_op       <= 3'b000;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_en        <= wr_en_d;
      wr_sel       <= wr_sel_d;
      wr_addr      <= wr_addr_d;
      wr_data      <= wr_data_d;
      alu_start    <= alu_start_d;
      alu_op       <= alu_op_d;
      result_valid <= result_valid_d;
      busy         <= busy_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Scenario-driven self-checking bench for matrix_op_sequencer.
module tb_matrix_op_sequencer;
  import matrix_pkg::*;

  localparam int unsigned W       = 8;
  localparam int unsigned ELEMS   = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned AW      = $clog2(ELEMS);

  logic          clk, nrst;
  logic [2:0]    op_code;
  logic          is_op, is_enter, num_valid, alu_done;
  logic [W-1:0]  num_val;
  logic          wr_en, wr_sel, alu_start, result_valid, busy, err;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [2:0]    alu_op, state;

  int checks = 0;
  int passed = 0;

  matrix_op_sequencer #(.W(W), .ELEMS(ELEMS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst), .op_code(op_code), .is_op(is_op), .is_enter(is_enter),
    .num_valid(num_valid), .num_val(num_val), .alu_done(alu_done),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_start(alu_start), .alu_op(alu_op), .result_valid(result_valid),
    .busy(busy), .err(err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Stimulus drivers (no checking): inputs change 1ns after a rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press_num(input logic [W-1:0] v);
    num_valid = 1'b1; num_val = v; tick(); num_valid = 1'b0;
  endtask

  task automatic press_op(input logic [2:0] c);
    is_op = 1'b1; op_code = c; tick(); is_op = 1'b0;
  endtask

  task automatic press_enter();
    is_enter = 1'b1; tick(); is_enter = 1'b0;
  endtask

  function automatic logic [2:0] bad_op();
    logic [2:0] c;
    do c = 3'($urandom_range(0, 7)); while (c == OP_ADD || c == OP_SUB);
    return c;
  endfunction

  task automatic drive_to_run(input logic [2:0] op);
    for (int i = 0; i < ELEMS; i++) press_num(W'($urandom));
    press_op(op);
    for (int i = 0; i < ELEMS; i++) press_num(W'($urandom));
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wr_en, wr_sel, wr_addr, wr_data, alu_start, alu_op, result_valid, busy, err} !== '0)
      $display("FAIL reset_outputs got %h exp 0", {wr_en, wr_sel, wr_addr, wr_data, alu_start, alu_op, result_valid, busy, err});
    else passed++;
    checks++;
    if (state !== 3'(LOAD_A)) $display("FAIL reset_state got %0d exp %0d", state, LOAD_A); else passed++;
    #2 nrst = 1'b1;
    tick();
  endtask

  task automatic test_load_a();
    for (int i = 0; i < ELEMS; i++) begin
      press_num(W'(i + 1));
      checks++;
      if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 1'b0, AW'(i), W'(i + 1)})
        $display("FAIL load_a_write%0d got en=%b sel=%b addr=%0d data=%0d exp 1/0/%0d/%0d", i, wr_en, wr_sel, wr_addr, wr_data, i, i + 1);
      else passed++;
    end
    checks++;
    if (state !== 3'(WAIT_OP)) $display("FAIL load_a_state got %0d exp %0d", state, WAIT_OP); else passed++;
    tick();
    checks++;
    if (wr_en !== 1'b0) $display("FAIL load_a_single_cycle got wr_en=%b exp 0", wr_en); else passed++;
  endtask

  task automatic test_wait_op();
    logic [2:0] codes [2];
    codes[0] = 3'b011;
    codes[1] = bad_op();
    foreach (codes[k]) begin
      press_op(codes[k]);
      checks++;
      if ({err, state} !== {1'b1, 3'(WAIT_OP)}) $display("FAIL wait_op_bad%0d got err=%b state=%0d exp 1/%0d", k, err, state, WAIT_OP); else passed++;
      tick();
      checks++;
      if (err !== 1'b0) $display("FAIL wait_op_err_pulse got %b exp 0", err); else passed++;
    end
    press_num(W'($urandom));
    checks++;
    if ({wr_en, err, state} !== {2'b00, 3'(WAIT_OP)}) $display("FAIL wait_op_num got en=%b err=%b state=%0d exp 0/0/%0d", wr_en, err, state, WAIT_OP); else passed++;
    press_op(OP_ADD);
    checks++;
    if ({alu_op, state, err} !== {OP_ADD, 3'(LOAD_B), 1'b0}) $display("FAIL wait_op_add got op=%0d state=%0d err=%b exp 1/%0d/0", alu_op, state, err, LOAD_B); else passed++;
  endtask

  task automatic test_load_b_run();
    for (int i = 0; i < ELEMS; i++) begin
      press_num(W'(i + 5));
      checks++;
      if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 1'b1, AW'(i), W'(i + 5)})
        $display("FAIL load_b_write%0d got en=%b sel=%b addr=%0d data=%0d exp 1/1/%0d/%0d", i, wr_en, wr_sel, wr_addr, wr_data, i, i + 5);
      else passed++;
      checks++;
      if (alu_start !== (i == ELEMS - 1)) $display("FAIL load_b_start%0d got %b exp %b", i, alu_start, i == ELEMS - 1); else passed++;
    end
    checks++;
    if ({state, busy} !== {3'(RUN), 1'b1}) $display("FAIL run_entry got state=%0d busy=%b exp %0d/1", state, busy, RUN); else passed++;
    // alu_done in the start cycle must be ignored.
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    checks++;
    if ({state, alu_start} !== {3'(RUN), 1'b0}) $display("FAIL run_early_done got state=%0d start=%b exp %0d/0", state, alu_start, RUN); else passed++;
    tick(); tick();
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    checks++;
    if ({state, result_valid, busy, alu_op} !== {3'(SHOW), 1'b1, 1'b0, OP_ADD})
      $display("FAIL show_entry got state=%0d rv=%b busy=%b op=%0d exp %0d/1/0/1", state, result_valid, busy, alu_op, SHOW);
    else passed++;
    press_num(W'($urandom));
    checks++;
    if ({state, wr_en} !== {3'(SHOW), 1'b0}) $display("FAIL show_num got state=%0d en=%b exp %0d/0", state, wr_en, SHOW); else passed++;
    press_enter();
    checks++;
    if ({state, result_valid} !== {3'(LOAD_A), 1'b0}) $display("FAIL show_exit got state=%0d rv=%b exp %0d/0", state, result_valid, LOAD_A); else passed++;
  endtask

  task automatic test_timeout();
    int n = 0;
    int errs = 0;
    drive_to_run(OP_SUB);
    while (state !== 3'(FAULT) && n < 40) begin
      is_op = 1'b1; op_code = OP_ADD; num_valid = 1'($urandom);
      tick();
      is_op = 1'b0; num_valid = 1'b0;
      n++;
      if (err === 1'b1) errs++;
    end
    checks++;
    if (n !== TIMEOUT) $display("FAIL timeout_cycles got %0d exp %0d", n, TIMEOUT); else passed++;
    checks++;
    if ({errs, err} !== {32'd1, 1'b1}) $display("FAIL timeout_err got pulses=%0d err=%b exp 1/1", errs, err); else passed++;
    press_op(OP_ADD);
    checks++;
    if ({state, err} !== {3'(FAULT), 1'b0}) $display("FAIL fault_op got state=%0d err=%b exp %0d/0", state, err, FAULT); else passed++;
    press_num(W'($urandom));
    checks++;
    if ({state, wr_en} !== {3'(FAULT), 1'b0}) $display("FAIL fault_num got state=%0d en=%b exp %0d/0", state, wr_en, FAULT); else passed++;
    press_enter();
    checks++;
    if ({state, alu_op} !== {3'(LOAD_A), 3'b000}) $display("FAIL fault_exit got state=%0d op=%0d exp %0d/0", state, alu_op, LOAD_A); else passed++;
  endtask

  task automatic test_abort();
    logic [W-1:0] v;
    for (int i = 0; i < ELEMS; i++) press_num(W'($urandom));
    press_op(OP_SUB);
    press_num(W'($urandom));
    press_num(W'($urandom));
    is_enter = 1'b1; num_valid = 1'b1; num_val = W'($urandom);
    tick();
    is_enter = 1'b0; num_valid = 1'b0;
    checks++;
    if ({wr_en, state, alu_op} !== {1'b0, 3'(LOAD_A), 3'b000})
      $display("FAIL abort got en=%b state=%0d op=%0d exp 0/%0d/0", wr_en, state, alu_op, LOAD_A);
    else passed++;
    v = W'($urandom);
    press_num(v);
    checks++;
    if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 1'b0, AW'(0), v})
      $display("FAIL abort_restart got en=%b sel=%b addr=%0d data=%0d exp 1/0/0/%0d", wr_en, wr_sel, wr_addr, wr_data, v);
    else passed++;
    press_enter();
  endtask

  task automatic test_op_in_load();
    logic [W-1:0] v = W'($urandom);
    is_op = 1'b1; op_code = OP_ADD; num_valid = 1'b1; num_val = v;
    tick();
    is_op = 1'b0; num_valid = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data, err, state} !== {1'b1, AW'(0), v, 1'b1, 3'(LOAD_A)})
      $display("FAIL load_op got en=%b addr=%0d data=%0d err=%b state=%0d exp 1/0/%0d/1/%0d", wr_en, wr_addr, wr_data, err, state, v, LOAD_A);
    else passed++;
    tick();
    checks++;
    if (err !== 1'b0) $display("FAIL load_op_pulse got %b exp 0", err); else passed++;
    press_enter();
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] v = W'($urandom);
    drive_to_run(OP_SUB);
    tick(); tick();
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_sel, wr_addr, wr_data, alu_start, alu_op, result_valid, busy, err, state} !== '0)
      $display("FAIL async_reset got %h exp 0", {wr_en, wr_sel, wr_addr, wr_data, alu_start, alu_op, result_valid, busy, err, state});
    else passed++;
    tick();
    #2 nrst = 1'b1;
    press_num(v);
    checks++;
    if ({wr_en, wr_sel, wr_addr, wr_data, state} !== {1'b1, 1'b0, AW'(0), v, 3'(LOAD_A)})
      $display("FAIL reset_resume got en=%b sel=%b addr=%0d data=%0d state=%0d exp 1/0/0/%0d/%0d", wr_en, wr_sel, wr_addr, wr_data, state, v, LOAD_A);
    else passed++;
    press_enter();
  endtask

  // Randomized full transactions: expected writes come from the entered data,
  // completion is expected exactly one cycle after the chosen alu_done latency.
  task automatic test_back_to_back();
    for (int it = 0; it < 6; it++) begin
      logic [2:0] op = ($urandom_range(0, 1) != 0) ? OP_ADD : OP_SUB;
      int lat = $urandom_range(1, TIMEOUT - 1);
      int bad = 0;
      for (int s = 0; s < 2; s++) begin
        for (int e = 0; e < ELEMS; e++) begin
          logic [W-1:0] v = W'($urandom);
          press_num(v);
          checks++;
          if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 1'(s), AW'(e), v})
            $display("FAIL b2b%0d_write s=%0d e=%0d got en=%b sel=%b addr=%0d data=%0d exp 1/%0d/%0d/%0d", it, s, e, wr_en, wr_sel, wr_addr, wr_data, s, e, v);
          else passed++;
        end
        if (s == 0) press_op(op);
      end
      checks++;
      if ({alu_start, alu_op} !== {1'b1, op}) $display("FAIL b2b%0d_start got start=%b op=%0d exp 1/%0d", it, alu_start, alu_op, op); else passed++;
      for (int k = 0; k < lat; k++) begin
        is_op = 1'($urandom); is_enter = 1'($urandom); num_valid = 1'($urandom);
        tick();
        is_op = 1'b0; is_enter = 1'b0; num_valid = 1'b0;
        if ({busy, wr_en, err} !== 3'b100) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL b2b%0d_run_noise got %0d bad cycles exp 0", it, bad); else passed++;
      alu_done = 1'b1; tick(); alu_done = 1'b0;
      checks++;
      if ({state, result_valid, alu_op} !== {3'(SHOW), 1'b1, op})
        $display("FAIL b2b%0d_show lat=%0d got state=%0d rv=%b op=%0d exp %0d/1/%0d", it, lat, state, result_valid, alu_op, SHOW, op);
      else passed++;
      if ($urandom_range(0, 1) != 0) press_enter(); else press_op(3'($urandom));
      checks++;
      if (state !== 3'(LOAD_A)) $display("FAIL b2b%0d_exit got state=%0d exp %0d", it, state, LOAD_A); else passed++;
    end
  endtask

  initial begin
    nrst = 1'b0; op_code = 3'b000; is_op = 1'b0; is_enter = 1'b0;
    num_valid = 1'b0; num_val = '0; alu_done = 1'b0;
    test_reset();
    test_load_a();
    test_wait_op();
    test_load_b_run();
    test_timeout();
    test_abort();
    test_op_in_load();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/matrix_op_sequencer.md
# matrix_op_sequencer

Top-level control FSM for the matrix calculator. Consumes one-cycle key events from the opcode encoder (`op_code`, `is_op`, `is_enter`) and the numeric entry path (`num_valid`, `num_val`), sequences element writes for operand matrices A and B into the operand register file, launches the arithmetic unit with the latched opcode, and holds the result for display. Sits between the keypad front-end and the matrix ALU/register file.

## Interface
Parameters:
- `W`, 8: element width in bits.
- `ELEMS`, 4: elements per matrix (2x2); index width `AW = $clog2(ELEMS)`.
- `TIMEOUT`, 15: max cycles to wait for `alu_done` after `alu_start`.

Ports:
- `clk`  in  1  system clock; one clock domain, all logic rising-edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `op_code`  in  3  opcode from encoder; valid only while `is_op`=1.
- `is_op`  in  1  one-cycle operator key event.
- `is_enter`  in  1  one-cycle enter/clear key event.
- `num_valid`  in  1  one-cycle numeric entry strobe.
- `num_val`  in  W  numeric value; valid with `num_valid`.
- `alu_done`  in  1  ALU completion pulse.
- `wr_en`  out  1  operand register-file write strobe.
- `wr_sel`  out  1  0 = matrix A, 1 = matrix B.
- `wr_addr`  out  AW  element index.
- `wr_data`  out  W  element value.
- `alu_start`  out  1  one-cycle launch pulse.
- `alu_op`  out  3  latched opcode, stable from `alu_start` until next LOAD_A entry.
- `result_valid`  out  1  high while in SHOW.
- `busy`  out  1  high while in RUN.
- `err`  out  1  one-cycle error pulse.
- `state`  out  3  current state encoding (debug/display).

## Operation
- States: LOAD_A, WAIT_OP, LOAD_B, RUN, SHOW, FAULT. Reset state LOAD_A, index 0, `alu_op`=0.
- LOAD_A / LOAD_B: each `num_valid` writes `num_val` to element `idx` of A / B, `idx`++. On the write of element ELEMS-1, `idx` wraps to 0 and the FSM advances (LOAD_A→WAIT_OP, LOAD_B→RUN). `is_op` here is rejected with an `err` pulse; if `is_op` and `num_valid` coincide, the write proceeds and `err` still pulses.
- WAIT_OP: `is_op` with `op_code` ∈ {3'b001 add, 3'b010 sub} latches `alu_op` and moves to LOAD_B. Any other code: `err` pulse, stay. `num_valid` is ignored without error.
- RUN: `alu_start` is high for the first RUN cycle only. The cycle counter starts at 0 on entry. `alu_done` is honoured from the cycle after `alu_start`; on `alu_done` → SHOW. If the counter reaches TIMEOUT without `alu_done` → FAULT with an `err` pulse. `is_enter`, `is_op`, `num_valid` are ignored.
- SHOW: `result_valid`=1. `is_enter` or `is_op` → LOAD_A (idx 0). `num_valid` is ignored.
- FAULT: only `is_enter` → LOAD_A.
- `is_enter` in LOAD_A, WAIT_OP, LOAD_B: abort to LOAD_A, idx 0, `alu_op` cleared. It takes priority over a coincident `num_valid` (no write).
- Reset mid-operation: all state returns to reset values immediately (async); no pending write or start survives.

## Timing
- All outputs are registered. Reset values: every output 0, `state`=LOAD_A encoding.
- Write latency: `num_valid` sampled at edge N → `wr_en`/`wr_sel`/`wr_addr`/`wr_data` valid in cycle N+1 for exactly one cycle.
- The last B write and the first RUN cycle (`alu_start`) occur in the same cycle, so the ALU sees a complete B when it starts.
- `alu_done` arriving in the `alu_start` cycle is ignored.
- `err` is a single-cycle pulse in the cycle after the offending event.
- The encoder provides one event per key press; no back-to-back hold behaviour is required.

## Structure
- Shared package `matrix_pkg`: state enum (`LOAD_A`..`FAULT`, 3-bit), opcode constants `OP_ADD`=3'b001 and `OP_SUB`=3'b010, and default `W`/`ELEMS`.
- One sub-module, `elem_counter`: an AW-bit index with `clear`, `inc`, and a `last` flag (idx == ELEMS-1). It is instanced once and shared by LOAD_A and LOAD_B.

## Test plan
- Enter 1,2,3,4 → four writes `wr_sel`=0, addr 0..3, data 1..4, one cycle after each strobe; `state`=WAIT_OP after the 4th.
- In WAIT_OP, `is_op` with `op_code`=3'b011 → `err` pulse, stay; then 3'b001 → `alu_op`=001, LOAD_B.
- Enter 5,6,7,8 → B writes; `alu_start` one cycle, coincident with the addr-3 write; `alu_done` 3 cycles later → SHOW, `result_valid`=1; `is_enter` → LOAD_A.
- In RUN, withhold `alu_done` → FAULT after 15 cycles, one `err` pulse; `is_op` has no effect; `is_enter` → LOAD_A.
- After 2 B elements, `is_enter` with a coincident `num_valid` → no write, LOAD_A, idx 0, `alu_op`=0.
- Deassert `nrst` during RUN → all outputs 0 asynchronously; resume at LOAD_A.
